// File: rtl/gray_rx_monitor.sv
// gray_rx_monitor: synchronises a Gray-coded counter, decodes it, checks each step and counts wraps
module gray_rx_monitor #(
    parameter int CBITS       = 9,
    parameter int SYNC_STAGES = 2,
    parameter int WBITS       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CBITS-1:0] gray_in,
    input  logic             sig_in,
    input  logic             clr_err,
    output logic [CBITS-1:0] bin_out,
    output logic             bin_vld,
    output logic             wrap_pulse,
    output logic [WBITS-1:0] wrap_cnt,
    output logic             step_err
);
    typedef enum logic [1:0] {FILL, ACQ, TRACK, ERR} state_t;
    localparam logic [2:0] FILL_END = 3'(SYNC_STAGES - 1);
    state_t state, next;
    logic [CBITS-1:0] gsync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] ssync;
    logic [CBITS-1:0] gs, b, prev_gray, prev_bin, diff;
    logic ss, ez, clr, ok_step, bad, do_step, do_err, do_wrap, cap;
    logic [2:0] fill;
    assign gs = gsync[SYNC_STAGES-1];
    assign ss = ssync[SYNC_STAGES-1];
    assign diff = gs ^ prev_gray;
    assign clr = clr_err && state != FILL;
    always_comb begin
        b = '0;
        for (int i = 0; i < CBITS; i++) b[i] = ^(gs >> i);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) gsync[i] <= '0;
            ssync <= '0;
        end else begin
            gsync[0] <= gray_in;
            ssync[0] <= sig_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                gsync[i] <= gsync[i-1];
                ssync[i] <= ssync[i-1];
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FILL;
        else state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            FILL:    next = (fill == FILL_END) ? ACQ : FILL;
            ACQ:     next = TRACK;
            TRACK:   next = bad ? ERR : TRACK;
            default: next = ERR;
        endcase
        if (clr) next = ACQ;
    end
    // a pending marker turns any non-zero forward step into an error
    always_comb begin
        ok_step = $onehot(diff) && b == prev_bin + CBITS'(1) && (!ez || b == '0);
        bad = diff != '0 && !ok_step;
        do_step = state == TRACK && !clr && ok_step;
        do_err = state == TRACK && !clr && bad;
        do_wrap = do_step && &prev_bin && b == '0;
        cap = state == ACQ || do_step;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill       <= '0;
            bin_out    <= '0;
            bin_vld    <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            step_err   <= 1'b0;
            prev_gray  <= '0;
            prev_bin   <= '0;
            ez         <= 1'b0;
        end else begin
            if (state == FILL) fill <= fill + 3'd1;
            bin_out    <= b;
            bin_vld    <= next == TRACK;
            wrap_pulse <= do_wrap;
            if (do_wrap && !(&wrap_cnt)) wrap_cnt <= wrap_cnt + WBITS'(1);
            if (cap) begin
                prev_gray <= gs;
                prev_bin  <= b;
            end
            step_err <= clr ? 1'b0 : (do_err ? 1'b1 : step_err);
            ez <= clr ? 1'b0 : (state != TRACK) ? ez : (do_step ? ss : (ez | ss));
        end
    end
endmodule

// File: tb/tb_gray_rx_monitor.sv
// tb_gray_rx_monitor: directed vectors against gray_rx_monitor, plus a narrow instance for wrap saturation
module tb_gray_rx_monitor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [8:0] gray_in = '0;
    logic sig_in = 1'b0, clr_err = 1'b0;
    logic [8:0] bin_out;
    logic bin_vld, wrap_pulse, step_err;
    logic [7:0] wrap_cnt;
    logic [2:0] sat_g = '0, sat_bin;
    logic sat_vld, sat_pulse, sat_err;
    logic [7:0] sat_cnt;
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    gray_rx_monitor dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .sig_in(sig_in), .clr_err(clr_err),
        .bin_out(bin_out), .bin_vld(bin_vld), .wrap_pulse(wrap_pulse),
        .wrap_cnt(wrap_cnt), .step_err(step_err)
    );
    gray_rx_monitor #(.CBITS(3)) u_sat (
        .clk(clk), .rst(rst), .gray_in(sat_g), .sig_in(1'b0), .clr_err(1'b0),
        .bin_out(sat_bin), .bin_vld(sat_vld), .wrap_pulse(sat_pulse),
        .wrap_cnt(sat_cnt), .step_err(sat_err)
    );
    function automatic logic [8:0] g9(input int v);
        return 9'(v ^ (v >> 1));
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic cyc(input logic [8:0] g, input logic s, input logic c);
        gray_in = g;
        sig_in = s;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bin", bin_out, 0);
        chk("rst_vld", bin_vld, 0);
        chk("rst_err", step_err, 0);
        rst = 1'b1;
        for (int v = 0; v < 512; v++) begin
            cyc(g9(v), 0, 0);
            if (v < 2) chk("fill_vld", bin_vld, 0);
            if (v >= 2 && v <= 6) begin
                chk("trk_bin", bin_out, v - 2);
                chk("trk_vld", bin_vld, 1);
                chk("trk_err", step_err, 0);
            end
        end
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("pre_wrap_bin", bin_out, 511);
        chk("pre_wrap_pulse", wrap_pulse, 0);
        chk("pre_wrap_cnt", wrap_cnt, 0);
        cyc(0, 0, 0);
        chk("wrap_bin", bin_out, 0);
        chk("wrap_pulse", wrap_pulse, 1);
        chk("wrap_cnt", wrap_cnt, 1);
        cyc(0, 0, 0);
        chk("wrap_pulse_end", wrap_pulse, 0);
        chk("wrap_cnt_hold", wrap_cnt, 1);
        cyc(1, 0, 0);
        cyc(3, 0, 0);
        cyc(9'h005, 0, 0);
        cyc(9'h005, 0, 0);
        chk("jump_pre_err", step_err, 0);
        chk("jump_pre_bin", bin_out, 2);
        cyc(9'h005, 0, 0);
        chk("jump_err", step_err, 1);
        chk("jump_bin", bin_out, 6);
        chk("jump_vld", bin_vld, 0);
        chk("jump_cnt", wrap_cnt, 1);
        repeat (3) cyc(2, 0, 0);
        chk("err_decode", bin_out, 3);
        chk("err_sticky", step_err, 1);
        chk("err_vld", bin_vld, 0);
        cyc(2, 0, 1);
        chk("clr_err", step_err, 0);
        chk("clr_vld", bin_vld, 0);
        cyc(2, 0, 0);
        chk("acq_vld", bin_vld, 1);
        cyc(2, 0, 0);
        chk("acq_no_err", step_err, 0);
        cyc(3, 0, 0);
        cyc(3, 0, 0);
        chk("back_pre_err", step_err, 0);
        cyc(3, 0, 0);
        chk("back_err", step_err, 1);
        chk("back_bin", bin_out, 2);
        chk("back_vld", bin_vld, 0);
        cyc(3, 0, 1);
        cyc(3, 0, 0);
        chk("reacq_vld", bin_vld, 1);
        cyc(3, 1, 0);
        cyc(2, 0, 0);
        cyc(2, 0, 0);
        chk("mark_hold_ok", step_err, 0);
        cyc(2, 0, 0);
        chk("mark_nonzero_err", step_err, 1);
        repeat (3) cyc(9'h100, 0, 0);
        cyc(9'h100, 0, 1);
        cyc(9'h100, 0, 0);
        chk("mark_acq_vld", bin_vld, 1);
        cyc(9'h100, 1, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("mark_zero_hold", step_err, 0);
        cyc(0, 0, 0);
        chk("mark_zero_err", step_err, 0);
        chk("mark_zero_pulse", wrap_pulse, 1);
        chk("mark_zero_cnt", wrap_cnt, 2);
        chk("mark_zero_vld", bin_vld, 1);
        for (int w = 0; w < 3; w++)
            for (int v = 1; v <= 512; v++) cyc(g9(v & 511), 0, 0);
        repeat (3) cyc(0, 0, 0);
        chk("five_wraps", wrap_cnt, 5);
        repeat (3) cyc(3, 0, 0);
        chk("pre_rst_err", step_err, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_bin", bin_out, 0);
        chk("async_vld", bin_vld, 0);
        chk("async_pulse", wrap_pulse, 0);
        chk("async_cnt", wrap_cnt, 0);
        chk("async_err", step_err, 0);
        cyc(0, 0, 0);
        chk("rst_held_cnt", wrap_cnt, 0);
        rst = 1'b1;
        for (int v = 0; v < 5; v++) begin
            cyc(g9(v), 0, 0);
            if (v < 2) chk("refill_vld", bin_vld, 0);
            else begin
                chk("resume_bin", bin_out, v - 2);
                chk("resume_vld", bin_vld, 1);
            end
        end
        chk("resume_err", step_err, 0);
        for (int i = 1; i <= 2400; i++) begin
            sat_g = 3'((i % 8) ^ ((i % 8) >> 1));
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sat_cnt", sat_cnt, 255);
        chk("sat_err", sat_err, 0);
        chk("sat_vld", sat_vld, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gray_rx_monitor.md
Name: gray_rx_monitor

Overview:
- Downstream consumer of the free-running Gray-code counter (gray_c / sig outputs).
- Synchronises the Gray bus into the local clock domain, decodes it to binary, and checks every step for legal single-bit forward motion.
- Detects wrap-around (max to 0), counts wraps, and flags protocol errors with a sticky flag.
- Feeds downstream timing/pointer logic with a trusted binary count.

Parameters:
- CBITS, 9, width of Gray bus and decoded count.
- SYNC_STAGES, 2, flop stages on gray_in/sig_in; legal range 1..4.
- WBITS, 8, width of wrap counter.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- gray_in  input  CBITS  Gray-coded count from upstream.
- sig_in  input  1  upstream zero marker: next new gray_in sample must decode to 0.
- clr_err  input  1  synchronous pulse; clears step_err and re-acquires.
- bin_out  output  CBITS  decoded binary count.
- bin_vld  output  1  bin_out is tracked and checked.
- wrap_pulse  output  1  one-cycle pulse on decoded transition from 2^CBITS-1 to 0.
- wrap_cnt  output  WBITS  number of wraps seen, saturating.
- step_err  output  1  sticky error flag.

Behaviour:
- Reset (rst=0, async):
  - All sync flops, bin_out, wrap_cnt, wrap_pulse, step_err, bin_vld = 0.
  - FSM = FILL; fill counter = 0; expect_zero = 0.
- Sync pipeline:
  - gray_in and sig_in pass through SYNC_STAGES flops in lockstep. Sync output = gs, ss.
  - No combinational path from inputs to outputs.
- Decode:
  - b[CBITS-1] = gs[CBITS-1]; b[i] = b[i+1] ^ gs[i].
  - Registered into bin_out.
  - Latency gray_in to bin_out = SYNC_STAGES+1 cycles.
- FSM:
  - FILL: count cycles; after SYNC_STAGES cycles go to ACQ. bin_vld = 0.
  - ACQ: one cycle; capture prev_gray = gs and prev_bin = b with no check. Go to TRACK; bin_vld = 1 from the next cycle.
  - TRACK, each cycle, comparing gs with prev_gray:
    - Hamming distance 0: hold; legal; no update.
    - Distance 1 and b == prev_bin+1 (mod 2^CBITS): legal step; update prev.
    - Distance 1 with any other b (backward step), or distance >1: error. step_err = 1; go to ERR.
  - ERR:
    - bin_out keeps decoding.
    - bin_vld = 0; no checks; no wrap counting.
    - step_err holds.
  - clr_err = 1 in any state except FILL: step_err = 0, go to ACQ.
  - clr_err in FILL is ignored.
- Wrap:
  - In TRACK, a legal step with prev_bin = 2^CBITS-1 and b = 0 sets wrap_pulse = 1 for exactly one cycle, aligned with bin_out = 0.
  - wrap_cnt increments on each wrap and saturates at 2^WBITS-1 (no roll-over).
- Marker check:
  - ss = 1 in TRACK sets expect_zero.
  - At the next legal step: b must equal 0, else error (-> ERR).
  - A hold cycle keeps expect_zero pending.
  - expect_zero clears on that step, on clr_err, and on reset.
- Simultaneous events:
  - Error detection and clr_err in the same cycle: clr_err wins (go to ACQ, step_err = 0).
  - Wrap and marker satisfied together is the normal case: both legal.
- Reset mid-operation: immediate return to FILL and all reset values. wrap_cnt is not preserved.

Test Plan:
- Reset release, gray_in stepping 0,1,3,2,6 (bin 0..4) one per cycle, SYNC_STAGES=2 -> bin_vld rises after fill+ACQ; bin_out shows 0,1,2,3,4 delayed 3 cycles; step_err = 0.
- Gray sequence through 0x101 (bin 510), 0x100 (bin 511), 0x000 -> wrap_pulse high exactly one cycle with bin_out = 0; wrap_cnt 0 to 1; 300 full wraps with WBITS=8 -> wrap_cnt holds at 255.
- Jump gray 0x003 to 0x005 (two bits differ) -> step_err = 1 three cycles later and stays; bin_vld = 0; wrap_cnt frozen.
- Backward step gray 0x002 to 0x003 (bin 3 to 2) -> step_err = 1; then clr_err pulse -> step_err = 0, ACQ, bin_vld = 1 after one cycle with no false error.
- sig_in = 1 followed by next sample gray 0x001 instead of 0x000 -> step_err = 1; same with 0x000 -> no error.
- rst asserted (0) mid-stream with wrap_cnt = 5, step_err = 1 -> all outputs 0 immediately (async); after release, FILL then ACQ, normal tracking resumes.
